t05_huffman_stream_decoder: RTL and testbench

Parametrised Huffman decoder that turns a byte stream of compressed data into decoded symbols. It keeps a left-aligned bit accumulator and matches it against variable-length, left-aligned codebook entries fetched through a request/valid port. It retires the matched code's bits and emits one symbol per match on a valid/ready output. It sits between the SPI read path and the decompressed-file writer, and is the successor to the fixed 128-bit, 256-entry bit-serial translator.

---
 rtl/t05_huff_pkg.sv | 19 +
 rtl/t05_huff_prefix_match.sv | 27 ++
 rtl/t05_huffman_stream_decoder.sv | 210 +++++++++++++++++++++
 tb/tb_t05_huffman_stream_decoder.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/t05_huff_pkg.sv
// Shared types and defaults for the t05 Huffman stream decoder.
package t05_huff_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_REQ,
        ST_WAIT,
        ST_EMIT,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam int BYTE_W           = 8;
    localparam int DEF_SYM_W        = 8;
    localparam int DEF_NUM_SYMS     = 256;
    localparam int DEF_MAX_CODE_LEN = 128;

endpackage

// File: rtl/t05_huff_prefix_match.sv
// Combinational compare of the top cb_len bits of the accumulator against a
// left-aligned codebook entry.
module t05_huff_prefix_match
    import t05_huff_pkg::*;
#(
    parameter int MAX_CODE_LEN = DEF_MAX_CODE_LEN,
    parameter int LEN_W        = $clog2(MAX_CODE_LEN + 1)
) (
    input  logic [MAX_CODE_LEN-1:0] acc,
    input  logic [LEN_W-1:0]        acc_len,
    input  logic [MAX_CODE_LEN-1:0] cb_code,
    input  logic [LEN_W-1:0]        cb_len,
    output logic                    match
);

    logic [MAX_CODE_LEN-1:0] ones;
    logic [MAX_CODE_LEN-1:0] mask;

    always_comb begin
        ones  = '1;
        // cb_len leading ones; a full-width length shifts every one out
        mask  = ~(ones >> cb_len);
        match = (cb_len != '0) && (cb_len <= acc_len) &&
                (((acc ^ cb_code) & mask) == '0);
    end

endmodule

// File: rtl/t05_huffman_stream_decoder.sv
// Byte-stream Huffman decoder: left-aligned bit accumulator scanned against a
// request/valid codebook. Option: T05_HUFF_SCAN_RESUME_EN resumes each scan at the last match.
module t05_huffman_stream_decoder
    import t05_huff_pkg::*;
#(
    parameter int SYM_W        = DEF_SYM_W,
    parameter int NUM_SYMS     = DEF_NUM_SYMS,
    parameter int MAX_CODE_LEN = DEF_MAX_CODE_LEN,
    parameter int LEN_W        = $clog2(MAX_CODE_LEN + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [31:0]             tot_syms,
    input  logic [7:0]              in_data,
    input  logic                    in_valid,
    input  logic                    in_last,
    output logic                    in_ready,
    output logic                    cb_req,
    output logic [SYM_W-1:0]        cb_addr,
    input  logic                    cb_valid,
    input  logic [MAX_CODE_LEN-1:0] cb_code,
    input  logic [LEN_W-1:0]        cb_len,
    output logic [SYM_W-1:0]        sym_data,
    output logic                    sym_valid,
    input  logic                    sym_ready,
    output logic                    busy,
    output logic                    done,
    output logic                    error
);

    localparam logic [LEN_W-1:0] FILL_LIM = LEN_W'(MAX_CODE_LEN - BYTE_W);
    localparam logic [LEN_W-1:0] BYTE_LEN = LEN_W'(BYTE_W);
    localparam logic [SYM_W-1:0] LAST_IDX = SYM_W'(NUM_SYMS - 1);

    state_t                  state_q, state_d;
    logic [MAX_CODE_LEN-1:0] acc_q, acc_d;
    logic [LEN_W-1:0]        acc_len_q, acc_len_d;
    logic [LEN_W-1:0]        len_q, len_d;
    logic [31:0]             tot_q, tot_d;
    logic [31:0]             sym_count_q, sym_count_d;
    logic                    eos_q, eos_d;
    logic [SYM_W-1:0]        scan_idx_q, scan_idx_d;
    logic [SYM_W-1:0]        scan_cnt_q, scan_cnt_d;

    logic                    in_ready_q, in_ready_d;
    logic                    cb_req_q, cb_req_d;
    logic [SYM_W-1:0]        cb_addr_q, cb_addr_d;
    logic [SYM_W-1:0]        sym_data_q, sym_data_d;
    logic                    sym_valid_q, sym_valid_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    error_q, error_d;

    logic                    match;
    logic [MAX_CODE_LEN-1:0] byte_al;

    t05_huff_prefix_match #(
        .MAX_CODE_LEN(MAX_CODE_LEN),
        .LEN_W       (LEN_W)
    ) u_match (
        .acc    (acc_q),
        .acc_len(acc_len_q),
        .cb_code(cb_code),
        .cb_len (cb_len),
        .match  (match)
    );

    always_comb begin
        byte_al                                 = '0;
        byte_al[MAX_CODE_LEN-1 -: BYTE_W]       = in_data;
        byte_al                                 = byte_al >> acc_len_q;

        state_d     = state_q;
        acc_d       = acc_q;
        acc_len_d   = acc_len_q;
        len_d       = len_q;
        tot_d       = tot_q;
        sym_count_d = sym_count_q;
        eos_d       = eos_q;
        scan_idx_d  = scan_idx_q;
        scan_cnt_d  = scan_cnt_q;
        sym_data_d  = sym_data_q;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    acc_d       = '0;
                    acc_len_d   = '0;
                    sym_count_d = '0;
                    eos_d       = 1'b0;
                    tot_d       = tot_syms;
                    scan_idx_d  = '0;
                    state_d     = (tot_syms == '0) ? ST_DONE : ST_FILL;
                end
            end
            ST_FILL: begin
                if (in_valid && in_ready_q) begin
                    acc_d     = acc_q | byte_al;
                    acc_len_d = acc_len_q + BYTE_LEN;
                    if (in_last) begin
                        eos_d = 1'b1;
                    end
                end
                // exit is judged on post-accept values so a threshold-crossing
                // or final byte moves straight on to the scan
                if ((acc_len_d > FILL_LIM) || eos_d) begin
                    if (acc_len_d == '0) begin
                        state_d = ST_ERR;
                    end else begin
                        scan_cnt_d = '0;
`ifdef T05_HUFF_SCAN_RESUME_EN
                        scan_idx_d = scan_idx_q;
`else
                        scan_idx_d = '0;
`endif
                        state_d    = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cb_valid) begin
                    if (match) begin
                        sym_data_d = scan_idx_q;
                        len_d      = cb_len;
                        state_d    = ST_EMIT;
                    end else if (scan_cnt_q == LAST_IDX) begin
                        state_d = ST_ERR;
                    end else begin
                        scan_cnt_d = scan_cnt_q + SYM_W'(1);
                        scan_idx_d = (scan_idx_q == LAST_IDX) ? '0 : scan_idx_q + SYM_W'(1);
                        state_d    = ST_REQ;
                    end
                end
            end
            ST_EMIT: begin
                if (sym_ready) begin
                    acc_d       = acc_q << len_q;
                    acc_len_d   = acc_len_q - len_q;
                    sym_count_d = sym_count_q + 32'd1;
                    state_d     = (sym_count_d == tot_q) ? ST_DONE : ST_FILL;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // outputs are decoded from next-state so they register alongside it
        in_ready_d  = (state_d == ST_FILL) && (acc_len_d <= FILL_LIM) && !eos_d;
        cb_req_d    = (state_d == ST_REQ);
        cb_addr_d   = (state_d == ST_REQ) ? scan_idx_d : cb_addr_q;
        sym_valid_d = (state_d == ST_EMIT);
        busy_d      = (state_d == ST_FILL) || (state_d == ST_REQ) ||
                      (state_d == ST_WAIT) || (state_d == ST_EMIT);
        done_d      = (state_d == ST_DONE);
        error_d     = (state_d == ST_ERR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            acc_len_q   <= '0;
            len_q       <= '0;
            tot_q       <= '0;
            sym_count_q <= '0;
            eos_q       <= 1'b0;
            scan_idx_q  <= '0;
            scan_cnt_q  <= '0;
            in_ready_q  <= 1'b0;
            cb_req_q    <= 1'b0;
            cb_addr_q   <= '0;
            sym_data_q  <= '0;
            sym_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            acc_len_q   <= acc_len_d;
            len_q       <= len_d;
            tot_q       <= tot_d;
            sym_count_q <= sym_count_d;
            eos_q       <= eos_d;
            scan_idx_q  <= scan_idx_d;
            scan_cnt_q  <= scan_cnt_d;
            in_ready_q  <= in_ready_d;
            cb_req_q    <= cb_req_d;
            cb_addr_q   <= cb_addr_d;
            sym_data_q  <= sym_data_d;
            sym_valid_q <= sym_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign cb_req    = cb_req_q;
    assign cb_addr   = cb_addr_q;
    assign sym_data  = sym_data_q;
    assign sym_valid = sym_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule

// File: tb/tb_t05_huffman_stream_decoder.sv
// Scoreboarded random bench for t05_huffman_stream_decoder with a bit-queue
// reference decoder and a randomly delayed codebook responder.
module tb_t05_huffman_stream_decoder;

    logic        clk, rst, start;
    logic [31:0] tot_syms;
    logic [7:0]  in_data;
    logic        in_valid, in_last, in_ready;
    logic        cb_req;
    logic [1:0]  cb_addr;
    logic        cb_valid;
    logic [15:0] cb_code;
    logic [4:0]  cb_len;
    logic [1:0]  sym_data;
    logic        sym_valid, sym_ready, busy, done, error;

    t05_huffman_stream_decoder #(
        .SYM_W       (2),
        .NUM_SYMS    (4),
        .MAX_CODE_LEN(16),
        .LEN_W       (5)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .tot_syms (tot_syms),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_last  (in_last),
        .in_ready (in_ready),
        .cb_req   (cb_req),
        .cb_addr  (cb_addr),
        .cb_valid (cb_valid),
        .cb_code  (cb_code),
        .cb_len   (cb_len),
        .sym_data (sym_data),
        .sym_valid(sym_valid),
        .sym_ready(sym_ready),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    logic [15:0]  cb_tab_code [4];
    logic [4:0]   cb_tab_len  [4];
    int unsigned  exp_q[$];
    int unsigned  hs_req[$];
    byte unsigned bq[$];
    int           n_checks = 0;
    int           n_fail   = 0;
    int           ready_pct = 100;
    bit           hold_first = 0;
    int           hold_left = 0;
    bit           cb_hold = 0;
    int unsigned  req_cnt = 0;
    int unsigned  inrdy_cnt = 0;
    int unsigned  valid_cnt = 0;
    int unsigned  last_reqs = 0;
    bit           pend = 0;
    logic [1:0]   pend_data = '0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_in_ready"}, 32'(in_ready), 0);
        chk({name, "_cb_req"}, 32'(cb_req), 0);
        chk({name, "_cb_addr"}, 32'(cb_addr), 0);
        chk({name, "_sym_data"}, 32'(sym_data), 0);
        chk({name, "_sym_valid"}, 32'(sym_valid), 0);
        chk({name, "_busy"}, 32'(busy), 0);
        chk({name, "_done"}, 32'(done), 0);
        chk({name, "_error"}, 32'(error), 0);
    endtask

    // codebook memory: answers each request after 1..3 cycles
    initial begin
        logic [1:0] a;
        int unsigned d;
        cb_valid = 0;
        cb_code  = '0;
        cb_len   = '0;
        forever begin
            @(negedge clk);
            if (cb_req && !rst && !cb_hold) begin
                a = cb_addr;
                d = $urandom_range(0, 2);
                @(posedge clk); #1;
                repeat (d) begin @(posedge clk); #1; end
                cb_valid = 1;
                cb_code  = cb_tab_code[a];
                cb_len   = cb_tab_len[a];
                @(posedge clk); #1;
                cb_valid = 0;
                cb_code  = 16'($urandom);
                cb_len   = 5'($urandom);
            end
        end
    end

    initial begin
        sym_ready = 0;
        forever begin
            @(posedge clk); #1;
            if (hold_first && sym_valid) begin
                hold_first = 0;
                hold_left  = 5;
            end
            if (hold_left > 0) begin
                sym_ready = 0;
                hold_left--;
            end else begin
                sym_ready = ($urandom_range(0, 99) < ready_pct);
            end
        end
    end

    // monitor: pops the scoreboard on every output handshake
    always @(negedge clk) begin
        if (rst) begin
            pend = 0;
        end else begin
            if (cb_req) req_cnt++;
            if (in_ready) inrdy_cnt++;
            if (sym_valid) valid_cnt++;
            if (pend) begin
                chk("hold_valid", 32'(sym_valid), 1);
                if (sym_valid) chk("hold_data", 32'(sym_data), 32'(pend_data));
            end
            if (sym_valid && sym_ready) begin
                hs_req.push_back(req_cnt);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sym_unexpected: got %0d expected no symbol", sym_data);
                end else begin
                    chk("sym", 32'(sym_data), exp_q.pop_front());
                end
                pend = 0;
            end else begin
                pend      = sym_valid;
                pend_data = sym_data;
            end
        end
    end

    // reference: walk the stream bit by bit, first codebook entry matching wins
    task automatic model(input byte unsigned bytes[$], input int unsigned tot, output bit err);
        bit bits[$];
        int pos;
        int n;
        int found;
        int rem;
        int l;
        bit ok;
        pos = 0;
        n   = 0;
        err = 0;
        foreach (bytes[i]) for (int b = 7; b >= 0; b--) bits.push_back(bytes[i][b]);
        while (n < int'(tot)) begin
            found = -1;
            rem   = bits.size() - pos;
            if (rem == 0) begin
                err = 1;
                break;
            end
            for (int k = 0; k < 4; k++) begin
                l = int'(cb_tab_len[k]);
                if (found < 0 && l > 0 && l <= rem) begin
                    ok = 1;
                    for (int j = 0; j < l; j++)
                        if (bits[pos+j] != cb_tab_code[k][15-j]) ok = 0;
                    if (ok) found = k;
                end
            end
            if (found < 0) begin
                err = 1;
                break;
            end
            exp_q.push_back(found);
            pos += int'(cb_tab_len[found]);
            n++;
        end
    endtask

    task automatic run_case(input byte unsigned bytes[$], input int unsigned tot, input int vld_pct);
        bit exp_err;
        int idx;
        int cyc;
        bit acc;
        int unsigned r0;
        exp_q.delete();
        model(bytes, tot, exp_err);
        r0 = req_cnt;
        hs_req.delete();
        inrdy_cnt = 0;
        valid_cnt = 0;
        idx = 0;
        cyc = 0;
        @(posedge clk); #1;
        start = 1;
        tot_syms = tot;
        @(posedge clk); #1;
        start = 0;
        while (!(done || error) && cyc < 5000) begin
            if (idx < bytes.size() && $urandom_range(0, 99) < vld_pct) begin
                in_valid = 1;
                in_data  = bytes[idx];
                in_last  = (idx == bytes.size() - 1);
            end else begin
                in_valid = 0;
                in_data  = 8'($urandom);
                in_last  = 1'($urandom);
            end
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) idx++;
            cyc++;
        end
        in_valid = 0;
        in_last  = 0;
        if (cyc >= 5000) begin
            n_checks++;
            n_fail++;
            $display("FAIL case_timeout: got no done/error expected one within 5000 cycles");
        end
        repeat (3) @(posedge clk);
        #1;
        chk("case_done", 32'(done), 32'(!exp_err));
        chk("case_error", 32'(error), 32'(exp_err));
        chk("case_left", exp_q.size(), 0);
        chk("case_busy", 32'(busy), 0);
        last_reqs = req_cnt - r0;
    endtask

    task automatic set_cb_abcd();
        cb_tab_code[0] = 16'h0000; cb_tab_len[0] = 5'd1;
        cb_tab_code[1] = 16'h8000; cb_tab_len[1] = 5'd2;
        cb_tab_code[2] = 16'hC000; cb_tab_len[2] = 5'd3;
        cb_tab_code[3] = 16'hE000; cb_tab_len[3] = 5'd3;
    endtask

    task automatic rand_cb();
        int unsigned lc[$];
        int unsigned ll[$];
        int unsigned s, c, l, k;
        lc.push_back(0);
        ll.push_back(0);
        repeat ($urandom_range(1, 3)) begin
            s = $urandom_range(0, lc.size() - 1);
            c = lc[s];
            l = ll[s];
            lc.delete(s);
            ll.delete(s);
            lc.push_back(c * 2);
            ll.push_back(l + 1);
            lc.push_back(c * 2 + 1);
            ll.push_back(l + 1);
        end
        for (int i = 0; i < 4; i++) begin
            cb_tab_len[i]  = '0;
            cb_tab_code[i] = 16'($urandom);
        end
        foreach (lc[i]) begin
            do k = $urandom_range(0, 3); while (cb_tab_len[k] != 0);
            cb_tab_len[k]  = 5'(ll[i]);
            cb_tab_code[k] = 16'(lc[i] << (16 - ll[i]));
        end
        if ($urandom_range(0, 3) == 0) cb_tab_len[$urandom_range(0, 3)] = '0;
    endtask

    initial begin
        int cyc;
        bit got;
        int unsigned exp_step;
        rst = 1; start = 0; tot_syms = 0;
        in_data = 0; in_valid = 0; in_last = 0;
        set_cb_abcd();
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        rst = 0;

        // 1001_1011 decodes B,A,C then leaves an unmatched "11"
        bq = {8'h9B};
        run_case(bq, 3, 100);
        run_case(bq, 4, 100);

        // stalled first symbol must hold its data
        hold_first = 1;
        bq = {8'hB0};
        run_case(bq, 2, 100);
        hold_first = 0;

        // every entry unused: full scan of 4 requests, then error
        for (int i = 0; i < 4; i++) begin
            cb_tab_len[i]  = '0;
            cb_tab_code[i] = 16'($urandom);
        end
        bq = {8'($urandom)};
        run_case(bq, 1, 100);
        chk("unused_reqs", last_reqs, 4);
        chk("unused_valid", valid_cnt, 0);

        // one 8-bit symbol then underrun
        for (int i = 0; i < 4; i++) begin
            cb_tab_code[i] = 16'(i << 8);
            cb_tab_len[i]  = 5'd8;
        end
        bq = {8'h00};
        run_case(bq, 3, 100);

        // tot_syms = 0: done next cycle, input never accepted
        inrdy_cnt = 0;
        in_valid = 1; in_data = 8'hAA; in_last = 1;
        @(posedge clk); #1;
        start = 1; tot_syms = 0;
        @(posedge clk); #1;
        start = 0;
        @(negedge clk);
        chk("zero_done", 32'(done), 1);
        chk("zero_busy", 32'(busy), 0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("zero_inready", inrdy_cnt, 0);
        chk("zero_sticky", 32'(done), 1);
        in_valid = 0; in_last = 0;

        // DDDD: scan cost per symbol depends on resume option
        set_cb_abcd();
        ready_pct = 100;
        bq = {8'hFF, 8'hF0};
        run_case(bq, 4, 100);
        chk("dddd_hs", hs_req.size(), 4);
        if (hs_req.size() == 4) begin
`ifdef T05_HUFF_SCAN_RESUME_EN
            exp_step = 1;
`else
            exp_step = 4;
`endif
            chk("dddd_first", hs_req[0] - (req_cnt - last_reqs), 4);
            for (int i = 1; i < 4; i++) chk("dddd_next", hs_req[i] - hs_req[i-1], exp_step);
        end

        for (int t = 0; t < 40; t++) begin
            rand_cb();
            bq = {};
            repeat ($urandom_range(1, 5)) bq.push_back(8'($urandom));
            ready_pct = $urandom_range(30, 100);
            run_case(bq, $urandom_range(1, 14), $urandom_range(40, 100));
        end

        // reset while waiting on the codebook
        ready_pct = 100;
        set_cb_abcd();
        cb_hold = 1;
        exp_q.delete();
        @(posedge clk); #1;
        start = 1; tot_syms = 1;
        @(posedge clk); #1;
        start = 0;
        in_valid = 1; in_data = 8'h80; in_last = 1;
        cyc = 0; got = 0;
        while (!got && cyc < 50) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 0; in_last = 0;
        chk("rstw_accept", 32'(got), 1);
        cyc = 0;
        while (!cb_req && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("rstw_req", 32'(cb_req), 1);
        @(posedge clk); #2;
        chk("rstw_busy", 32'(busy), 1);
        rst = 1;
        #1;
        chk_zero("rst_async");
        @(posedge clk); #1;
        chk_zero("rst_edge");
        cb_hold = 0;
        @(posedge clk); #1;
        rst = 0;

        rand_cb();
        bq = {8'($urandom), 8'($urandom), 8'($urandom)};
        run_case(bq, 6, 80);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
